// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and defaults for the RAM port-A arbiter
// (ram_2p_port_arb and its round-robin picker).
package ram_arb_pkg;

  // Default WAIT-state watchdog limit (only meaningful with RAM_ARB_TIMEOUT_EN).
  localparam int unsigned TimeoutCyclesDefault = 16;

  // Holding-register field widths sized for the largest supported build:
  // up to 8 requesters, up to 2^16 words, up to 64-bit data.
  localparam int unsigned ArbIdW      = 3;
  localparam int unsigned ArbAwMax    = 16;
  localparam int unsigned ArbWidthMax = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } ram_arb_state_e;

  // Everything needed to drive one RAM transaction and route its response.
  typedef struct packed {
    logic [ArbIdW-1:0]      id;
    logic                   we;
    logic [ArbAwMax-1:0]    addr;
    logic [ArbWidthMax-1:0] wdata;
    logic [ArbWidthMax-1:0] wmask;
  } ram_arb_txn_t;

endpackage

// File: rtl/ram_rr_picker.sv
// ram_rr_picker: purely combinational round-robin select. Scans requesters
// starting at the index after `last` and wraps, returning a one-hot grant
// and the binary index of the winner (both zero when nothing requests).
module ram_rr_picker
  import ram_arb_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   last,
  output logic [NumReq-1:0] gnt,
  output logic [IdxW-1:0]   idx
);

  logic            found_s;
  logic [IdxW-1:0] cand_s;

  // First requesting index after `last`, in wrap-around order, wins.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int unsigned i = 1; i <= NumReq; i++) begin
      cand_s = IdxW'((32'(last) + i) % NumReq);
      if (!found_s && req[cand_s]) begin
        found_s     = 1'b1;
        gnt[cand_s] = 1'b1;
        idx         = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/ram_2p_port_arb.sv
// ram_2p_port_arb: shares port A of prim_ram_2p among NumReq requesters.
// One transaction at a time: IDLE (grant) -> ISSUE (AR or AW/W valid) ->
// WAIT (response), with address/data held in a holding register until the
// response so the RAM may sample them late.
// Optional build macro RAM_ARB_TIMEOUT_EN adds a WAIT-state watchdog that
// answers with rsp_err_o=1 after TimeoutCycles WAIT cycles.
module ram_2p_port_arb
  import ram_arb_pkg::*;
#(
  parameter  int unsigned NumReq        = 2,
  parameter  int unsigned Width         = 32,
  parameter  int unsigned Depth         = 128,
  parameter  int unsigned TimeoutCycles = TimeoutCyclesDefault,
  localparam int unsigned Aw            = $clog2(Depth)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumReq-1:0]        req_i,
  output logic [NumReq-1:0]        gnt_o,
  input  logic [NumReq-1:0]        we_i,
  input  logic [NumReq*Aw-1:0]     addr_i,
  input  logic [NumReq*Width-1:0]  wdata_i,
  input  logic [NumReq*Width-1:0]  wmask_i,
  output logic [NumReq-1:0]        rsp_valid_o,
  output logic [Width-1:0]         rsp_rdata_o,
  output logic                     rsp_err_o,
  output logic                     ram_arvalid_o,
  output logic                     ram_awvalid_o,
  output logic                     ram_wvalid_o,
  output logic                     ram_write_o,
  output logic [Aw-1:0]            ram_araddr_o,
  output logic [Aw-1:0]            ram_awaddr_o,
  output logic [Width-1:0]         ram_wdata_o,
  output logic [Width-1:0]         ram_wmask_o,
  output logic                     ram_rready_o,
  output logic                     ram_bready_o,
  input  logic                     ram_rvalid_i,
  input  logic                     ram_bvalid_i,
  input  logic [Width-1:0]         ram_rdata_i
);

  localparam int unsigned IdxW = $clog2(NumReq);

  ram_arb_state_e    state_q, state_d;
  ram_arb_txn_t      txn_q, txn_d;
  logic [IdxW-1:0]   last_q, last_d;

  logic [NumReq-1:0] pick_gnt_s;
  logic [IdxW-1:0]   pick_idx_s;
  logic [Aw-1:0]     sel_addr_s;
  logic [Width-1:0]  sel_wdata_s;
  logic [Width-1:0]  sel_wmask_s;

  logic [NumReq-1:0] gnt_s;
  logic [NumReq-1:0] rsp_valid_s;
  logic [Width-1:0]  rsp_rdata_s;
  logic              rsp_err_s;
  logic              resp_hit_s;
  logic              timeout_hit_s;
  logic              busy_s;
  logic              issue_s;
  logic [IdxW-1:0]   id_s;
  logic              unused_txn_s;

  ram_rr_picker #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_picker (
    .req  (req_i),
    .last (last_q),
    .gnt  (pick_gnt_s),
    .idx  (pick_idx_s)
  );

  assign sel_addr_s  = addr_i[pick_idx_s*Aw +: Aw];
  assign sel_wdata_s = wdata_i[pick_idx_s*Width +: Width];
  assign sel_wmask_s = wmask_i[pick_idx_s*Width +: Width];

  assign id_s       = txn_q.id[IdxW-1:0];
  assign resp_hit_s = txn_q.we ? ram_bvalid_i : ram_rvalid_i;
  assign busy_s     = (state_q != IDLE);
  assign issue_s    = (state_q == ISSUE);

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Watchdog: cleared while entering WAIT, counts each WAIT cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ISSUE) begin
      cnt_d = '0;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_hit_s = (cnt_q == CntW'(TimeoutCycles));
`else
  localparam int unsigned unused_timeout_cycles = TimeoutCycles;
  assign timeout_hit_s = 1'b0;
`endif

  // Next-state, holding-register capture, grant and response decode.
  always_comb begin
    state_d     = state_q;
    txn_d       = txn_q;
    last_d      = last_q;
    gnt_s       = '0;
    rsp_valid_s = '0;
    rsp_rdata_s = '0;
    rsp_err_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          gnt_s       = pick_gnt_s;
          txn_d.id    = ArbIdW'(pick_idx_s);
          txn_d.we    = we_i[pick_idx_s];
          txn_d.addr  = ArbAwMax'(sel_addr_s);
          txn_d.wdata = ArbWidthMax'(sel_wdata_s);
          txn_d.wmask = ArbWidthMax'(sel_wmask_s);
          state_d     = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        // A matching valid wins over a watchdog expiry in the same cycle.
        if (resp_hit_s) begin
          rsp_valid_s[id_s] = 1'b1;
          rsp_rdata_s       = txn_q.we ? '0 : ram_rdata_i;
          last_d            = id_s;
          state_d           = IDLE;
        end else if (timeout_hit_s) begin
          rsp_valid_s[id_s] = 1'b1;
          rsp_err_s         = 1'b1;
          last_d            = id_s;
          state_d           = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, holding register and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      txn_q   <= '0;
      last_q  <= IdxW'(NumReq - 1);
    end else begin
      state_q <= state_d;
      txn_q   <= txn_d;
      last_q  <= last_d;
    end
  end

  // Grants and responses are suppressed while reset is asserted so nothing
  // is handed out or answered by a transaction that reset is discarding.
  assign gnt_o       = gnt_s & {NumReq{~rst_i}};
  assign rsp_valid_o = rsp_valid_s & {NumReq{~rst_i}};
  assign rsp_rdata_o = rsp_rdata_s & {Width{~rst_i}};
  assign rsp_err_o   = rsp_err_s & ~rst_i;

  assign ram_arvalid_o = issue_s & ~txn_q.we;
  assign ram_awvalid_o = issue_s & txn_q.we;
  assign ram_wvalid_o  = issue_s & txn_q.we;
  assign ram_write_o   = issue_s & txn_q.we;
  assign ram_rready_o  = (state_q == WAIT);
  assign ram_bready_o  = (state_q == WAIT);

  assign ram_araddr_o = busy_s ? txn_q.addr[Aw-1:0] : '0;
  assign ram_awaddr_o = busy_s ? txn_q.addr[Aw-1:0] : '0;
  assign ram_wdata_o  = busy_s ? txn_q.wdata[Width-1:0] : '0;
  assign ram_wmask_o  = busy_s ? txn_q.wmask[Width-1:0] : '0;

  // Holding-register fields are sized for the largest build; the spare
  // upper bits are always zero.
  assign unused_txn_s = ^txn_q;

endmodule

// File: tb/tb_ram_2p_port_arb.sv
// Directed self-checking bench for ram_2p_port_arb with a small port-A RAM
// model (configurable latency and stall). Honors RAM_ARB_TIMEOUT_EN.
module tb_ram_2p_port_arb;
  localparam int NumReq = 2;
  localparam int Width = 32;
  localparam int Depth = 128;
  localparam int Aw = 7;
  localparam int TimeoutCycles = 4;

  logic clk;
  logic rst_i;
  logic [NumReq-1:0] req_i, gnt_o, we_i, rsp_valid_o;
  logic [NumReq*Aw-1:0] addr_i;
  logic [NumReq*Width-1:0] wdata_i, wmask_i;
  logic [Width-1:0] rsp_rdata_o, ram_wdata_o, ram_wmask_o, ram_rdata_i;
  logic rsp_err_o, ram_arvalid_o, ram_awvalid_o, ram_wvalid_o, ram_write_o;
  logic [Aw-1:0] ram_araddr_o, ram_awaddr_o;
  logic ram_rready_o, ram_bready_o, ram_rvalid_i, ram_bvalid_i;

  int checks;
  int failures;

  ram_2p_port_arb #(
    .NumReq(NumReq), .Width(Width), .Depth(Depth), .TimeoutCycles(TimeoutCycles)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .wmask_i(wmask_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .ram_arvalid_o(ram_arvalid_o), .ram_awvalid_o(ram_awvalid_o),
    .ram_wvalid_o(ram_wvalid_o), .ram_write_o(ram_write_o),
    .ram_araddr_o(ram_araddr_o), .ram_awaddr_o(ram_awaddr_o),
    .ram_wdata_o(ram_wdata_o), .ram_wmask_o(ram_wmask_o),
    .ram_rready_o(ram_rready_o), .ram_bready_o(ram_bready_o),
    .ram_rvalid_i(ram_rvalid_i), .ram_bvalid_i(ram_bvalid_i),
    .ram_rdata_i(ram_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- port-A RAM model ----------------
  logic [31:0] mem [Depth];
  logic        m_pend, m_pwe, m_rvalid, m_bvalid;
  int          m_cnt;
  logic [31:0] m_rd;
  int          ram_lat;
  logic        ram_stall;
  logic        poke_en;
  logic [6:0]  poke_addr;
  logic [31:0] poke_data;

  assign ram_rvalid_i = m_rvalid;
  assign ram_bvalid_i = m_bvalid;
  assign ram_rdata_i  = m_rd;

  // RAM model: samples AR/AW at ISSUE, answers after ram_lat extra cycles.
  always @(posedge clk) begin
    m_rvalid <= 1'b0;
    m_bvalid <= 1'b0;
    if (poke_en) mem[poke_addr] <= poke_data;
    if (rst_i) begin
      m_pend <= 1'b0;
      m_cnt  <= 0;
    end else if (ram_arvalid_o || (ram_awvalid_o && ram_wvalid_o)) begin
      if (ram_awvalid_o && ram_wvalid_o && ram_write_o)
        mem[ram_awaddr_o] <= (mem[ram_awaddr_o] & ~ram_wmask_o) | (ram_wdata_o & ram_wmask_o);
      m_rd <= ram_awvalid_o ? 32'hBAD0BAD0 : mem[ram_araddr_o];
      if (ram_lat == 0 && !ram_stall) begin
        m_rvalid <= ram_arvalid_o;
        m_bvalid <= ram_awvalid_o;
      end else begin
        m_pend <= 1'b1;
        m_cnt  <= ram_lat;
        m_pwe  <= ram_awvalid_o;
      end
    end else if (m_pend && !ram_stall) begin
      if (m_cnt <= 1) begin
        m_rvalid <= !m_pwe;
        m_bvalid <= m_pwe;
        m_pend   <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_req(input int idx, input logic we, input logic [Aw-1:0] a,
                         input logic [31:0] d, input logic [31:0] m);
    we_i[idx] = we;
    addr_i[idx*Aw +: Aw] = a;
    wdata_i[idx*Width +: Width] = d;
    wmask_i[idx*Width +: Width] = m;
  endtask

  task automatic poke(input logic [6:0] a, input logic [31:0] d);
    step();
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    step();
    poke_en = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 1'b1; req_i = '0;
    step(); step();
    rst_i = 1'b0;
    step(); #1;
    checks++; if (gnt_o !== 2'b00) begin failures++; $display("FAIL rst_gnt got=%b exp=00", gnt_o); end
    checks++; if (rsp_valid_o !== 2'b00) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=00", rsp_valid_o); end
    checks++; if ({rsp_rdata_o, rsp_err_o} !== 33'h0) begin failures++; $display("FAIL rst_rsp got=%h/%b exp=0", rsp_rdata_o, rsp_err_o); end
    checks++; if ({ram_arvalid_o, ram_awvalid_o, ram_wvalid_o, ram_write_o, ram_rready_o, ram_bready_o} !== 6'b0)
      begin failures++; $display("FAIL rst_ctl got=%b%b%b%b%b%b exp=0", ram_arvalid_o, ram_awvalid_o, ram_wvalid_o, ram_write_o, ram_rready_o, ram_bready_o); end
    checks++; if ({ram_araddr_o, ram_awaddr_o, ram_wdata_o, ram_wmask_o} !== 78'h0)
      begin failures++; $display("FAIL rst_bus got=%h %h %h %h exp=0", ram_araddr_o, ram_awaddr_o, ram_wdata_o, ram_wmask_o); end
  endtask

  task automatic test_single_read();
    poke(7'd5, 32'hDEADBEEF);
    step(); set_req(0, 1'b0, 7'd5, 32'h0, 32'h0); req_i = 2'b01; #1;
    checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL rd_gnt got=%b exp=01", gnt_o); end
    checks++; if (rsp_valid_o !== 2'b00) begin failures++; $display("FAIL rd_rsp_early got=%b exp=00", rsp_valid_o); end
    step(); req_i = 2'b00; #1;
    checks++; if ({ram_arvalid_o, ram_awvalid_o} !== 2'b10) begin failures++; $display("FAIL rd_arvalid got=%b%b exp=10", ram_arvalid_o, ram_awvalid_o); end
    checks++; if (ram_araddr_o !== 7'd5) begin failures++; $display("FAIL rd_araddr got=%h exp=05", ram_araddr_o); end
    step(); #1;
    checks++; if (rsp_valid_o !== 2'b01) begin failures++; $display("FAIL rd_rsp_valid got=%b exp=01", rsp_valid_o); end
    checks++; if (rsp_rdata_o !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_rdata got=%h exp=deadbeef", rsp_rdata_o); end
    checks++; if (gnt_o !== 2'b00 || rsp_err_o !== 1'b0) begin failures++; $display("FAIL rd_gnt_err got=%b/%b exp=00/0", gnt_o, rsp_err_o); end
    step(); #1;
    checks++; if (rsp_valid_o !== 2'b00 || ram_rready_o !== 1'b0) begin failures++; $display("FAIL rd_idle got=%b/%b exp=00/0", rsp_valid_o, ram_rready_o); end
  endtask

  task automatic test_masked_write();
    poke(7'd3, 32'h0);
    step(); set_req(1, 1'b1, 7'd3, 32'hAABBCCDD, 32'h0000FFFF); req_i = 2'b10; #1;
    checks++; if (gnt_o !== 2'b10) begin failures++; $display("FAIL wr_gnt got=%b exp=10", gnt_o); end
    step(); req_i = 2'b00; #1;
    checks++; if ({ram_arvalid_o, ram_awvalid_o, ram_wvalid_o, ram_write_o} !== 4'b0111)
      begin failures++; $display("FAIL wr_ctl got=%b%b%b%b exp=0111", ram_arvalid_o, ram_awvalid_o, ram_wvalid_o, ram_write_o); end
    checks++; if ({ram_awaddr_o, ram_wdata_o, ram_wmask_o} !== {7'd3, 32'hAABBCCDD, 32'h0000FFFF})
      begin failures++; $display("FAIL wr_bus got=%h %h %h exp=03 aabbccdd 0000ffff", ram_awaddr_o, ram_wdata_o, ram_wmask_o); end
    step(); #1;
    checks++; if (rsp_valid_o !== 2'b10 || rsp_rdata_o !== 32'h0) begin failures++; $display("FAIL wr_rsp got=%b/%h exp=10/0", rsp_valid_o, rsp_rdata_o); end
    step(); set_req(1, 1'b0, 7'd3, 32'h0, 32'h0); req_i = 2'b10; #1;
    checks++; if (gnt_o !== 2'b10) begin failures++; $display("FAIL wrrd_gnt got=%b exp=10", gnt_o); end
    step(); req_i = 2'b00;
    step(); #1;
    checks++; if (rsp_valid_o !== 2'b10 || rsp_rdata_o !== 32'h0000CCDD) begin failures++; $display("FAIL wrrd_data got=%b/%h exp=10/0000ccdd", rsp_valid_o, rsp_rdata_o); end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_g;
    logic [31:0] exp_d;
    step();
    set_req(0, 1'b0, 7'd5, 32'h0, 32'h0);
    set_req(1, 1'b0, 7'd3, 32'h0, 32'h0);
    req_i = 2'b11;
    for (int t = 0; t < 6; t++) begin
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      exp_d = (t % 2 == 0) ? 32'hDEADBEEF : 32'h0000CCDD;
      #1;
      checks++; if (gnt_o !== exp_g) begin failures++; $display("FAIL fair_gnt t=%0d got=%b exp=%b", t, gnt_o, exp_g); end
      step(); #1;
      checks++; if (gnt_o !== 2'b00 || ram_arvalid_o !== 1'b1) begin failures++; $display("FAIL fair_issue t=%0d got=%b/%b exp=00/1", t, gnt_o, ram_arvalid_o); end
      step(); #1;
      checks++; if (rsp_valid_o !== exp_g || rsp_rdata_o !== exp_d || gnt_o !== 2'b00)
        begin failures++; $display("FAIL fair_rsp t=%0d got=%b/%h/%b exp=%b/%h/00", t, rsp_valid_o, rsp_rdata_o, gnt_o, exp_g, exp_d); end
      step();
    end
    req_i = 2'b00;
  endtask

  task automatic test_stability();
    bit done;
    ram_lat = 3;
    step(); set_req(0, 1'b1, 7'd9, 32'h12345678, 32'hFFFFFFFF); req_i = 2'b01; #1;
    checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL stab_gnt got=%b exp=01", gnt_o); end
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      step(); req_i = 2'b00; addr_i = ~addr_i; wdata_i = ~wdata_i; #1;
      if (k == 0) begin
        checks++; if (ram_awvalid_o !== 1'b1) begin failures++; $display("FAIL stab_awvalid got=%b exp=1", ram_awvalid_o); end
      end
      checks++; if (ram_awaddr_o !== 7'd9 || ram_wdata_o !== 32'h12345678)
        begin failures++; $display("FAIL stab_hold k=%0d got=%h/%h exp=09/12345678", k, ram_awaddr_o, ram_wdata_o); end
      if (rsp_valid_o == 2'b01) done = 1'b1;
    end
    checks++; if (!done) begin failures++; $display("FAIL stab_rsp got=none exp=rsp_valid 01 within 20 cycles"); end
    ram_lat = 0;
    step(); set_req(0, 1'b0, 7'd9, 32'h0, 32'h0); req_i = 2'b01;
    step(); req_i = 2'b00;
    step(); #1;
    checks++; if (rsp_valid_o !== 2'b01 || rsp_rdata_o !== 32'h12345678) begin failures++; $display("FAIL stab_readback got=%b/%h exp=01/12345678", rsp_valid_o, rsp_rdata_o); end
  endtask

  task automatic test_timeout();
    ram_stall = 1'b1;
    step(); set_req(1, 1'b0, 7'd5, 32'h0, 32'h0); req_i = 2'b10; #1;
    checks++; if (gnt_o !== 2'b10) begin failures++; $display("FAIL to_gnt got=%b exp=10", gnt_o); end
    step(); req_i = 2'b00;
    step();
`ifdef RAM_ARB_TIMEOUT_EN
    for (int i = 0; i < TimeoutCycles; i++) begin
      #1;
      checks++; if (rsp_valid_o !== 2'b00) begin failures++; $display("FAIL to_early i=%0d got=%b exp=00", i, rsp_valid_o); end
      step();
    end
    #1;
    checks++; if (rsp_valid_o !== 2'b10 || rsp_err_o !== 1'b1 || rsp_rdata_o !== 32'h0)
      begin failures++; $display("FAIL to_rsp got=%b/%b/%h exp=10/1/0", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
    step(); #1;
    checks++; if (ram_rready_o !== 1'b0) begin failures++; $display("FAIL to_idle got=%b exp=0", ram_rready_o); end
`else
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (rsp_valid_o !== 2'b00 || rsp_err_o !== 1'b0) begin failures++; $display("FAIL nto_rsp i=%0d got=%b/%b exp=00/0", i, rsp_valid_o, rsp_err_o); end
      step();
    end
    #1;
    checks++; if (ram_rready_o !== 1'b1) begin failures++; $display("FAIL nto_wait got=%b exp=1", ram_rready_o); end
`endif
  endtask

  task automatic test_reset_wait();
    ram_stall = 1'b0;
    step(); rst_i = 1'b1;
    step(); rst_i = 1'b0;
    // Complete one transaction from requester 0 so the pointer favours 1.
    step(); set_req(0, 1'b0, 7'd5, 32'h0, 32'h0); req_i = 2'b01; #1;
    checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL rw_gnt0 got=%b exp=01", gnt_o); end
    step(); req_i = 2'b00;
    step(); step();
    // Start a transaction from requester 1 that the RAM never answers.
    ram_stall = 1'b1;
    set_req(1, 1'b0, 7'd3, 32'h0, 32'h0); req_i = 2'b10; #1;
    checks++; if (gnt_o !== 2'b10) begin failures++; $display("FAIL rw_gnt1 got=%b exp=10", gnt_o); end
    step(); req_i = 2'b00;
    step(); step(); #1;
    checks++; if (ram_rready_o !== 1'b1) begin failures++; $display("FAIL rw_inwait got=%b exp=1", ram_rready_o); end
    step(); rst_i = 1'b1; req_i = 2'b11; #1;
    checks++; if (gnt_o !== 2'b00 || rsp_valid_o !== 2'b00) begin failures++; $display("FAIL rw_during got=%b/%b exp=00/00", gnt_o, rsp_valid_o); end
    step(); rst_i = 1'b0; req_i = 2'b00; ram_stall = 1'b0; #1;
    checks++; if ({gnt_o, rsp_valid_o, rsp_err_o, ram_arvalid_o, ram_awvalid_o, ram_rready_o, ram_bready_o} !== 9'b0)
      begin failures++; $display("FAIL rw_after got=%b %b %b %b%b%b%b exp=0", gnt_o, rsp_valid_o, rsp_err_o, ram_arvalid_o, ram_awvalid_o, ram_rready_o, ram_bready_o); end
    checks++; if ({ram_araddr_o, rsp_rdata_o} !== 39'h0) begin failures++; $display("FAIL rw_after_bus got=%h/%h exp=0", ram_araddr_o, rsp_rdata_o); end
    step(); req_i = 2'b11; #1;
    checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL rw_first got=%b exp=01", gnt_o); end
    step(); req_i = 2'b00;
    step(); #1;
    checks++; if (rsp_valid_o !== 2'b01 || rsp_rdata_o !== 32'hDEADBEEF) begin failures++; $display("FAIL rw_rsp got=%b/%h exp=01/deadbeef", rsp_valid_o, rsp_rdata_o); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_i = 1'b1; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; wmask_i = '0;
    ram_lat = 0; ram_stall = 1'b0; poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    test_reset();
    test_single_read();
    test_masked_write();
    test_fairness();
    test_stability();
    test_timeout();
    test_reset_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
